// File: rtl/scan_cell.sv
`default_nettype none
// ============================================================================
// Module   : scan_cell
// Purpose  : Mux-D scan flip-flop. Functional mode (se = 0) captures d;
//            scan mode (se = 1) captures si, so that cells connected
//            so -> si form a serial shift register for test access.
// Ports    : clk   - rising-edge clock (only clock)
//            reset - asynchronous, active-low reset; forces the bit to
//                    RESET_VAL without a clock
//            d     - functional data input, sampled when se = 0
//            si    - scan serial input, sampled when se = 1
//            se    - scan enable (1 = shift, 0 = functional)
//            so    - registered storage bit; feeds both the functional
//                    fanout and the next cell's si
// Params   : RESET_VAL - value held by the storage bit during reset
// Revision : 1.0 - initial release
// ============================================================================
module scan_cell #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    input  logic si,
    input  logic se,
    output logic so
);

    logic w_store_d;
    logic r_store_q;

    // Select the source of the next stored value. se is not pipelined,
    // so a mode change made between edges applies at the very next edge.
    always_comb begin
        w_store_d = d;
        if (se) begin
            w_store_d = si;
        end
    end

    // The reset branch does not depend on clk, so assertion takes effect
    // immediately and holds the bit until the first clean rising edge
    // after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_store_q <= RESET_VAL;
        end else begin
            r_store_q <= w_store_d;
        end
    end

    // Straight from the flop: there is no combinational path from any
    // input to so, so chained cells shift exactly one bit per clock.
    assign so = r_store_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_cell.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_cell
// Purpose  : Self-checking bench for scan_cell: directed scenarios followed
//            by randomized stimulus, checked against a behavioural model of
//            the stored bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_cell;

    localparam logic c_RESET_VAL = 1'b0;

    logic clk;
    logic reset;
    logic d;
    logic si;
    logic se;
    logic so;

    int   n_cmp;
    int   n_err;
    logic model_bit;

    scan_cell #(
        .RESET_VAL (c_RESET_VAL)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .si    (si),
        .se    (se),
        .so    (so)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: so=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural rule for one rising edge: the bit becomes whichever input
    // the scan enable selects.
    task automatic model_edge();
        model_bit = (se === 1'b1) ? si : d;
    endtask

    // Drive inputs on the falling edge, clock them in, check after the edge.
    task automatic run_cycle(input string tag, input logic i_d, input logic i_si,
                             input logic i_se);
        @(negedge clk);
        d  = i_d;
        si = i_si;
        se = i_se;
        @(posedge clk);
        model_edge();
        #1;
        check_bit(tag, so, model_bit);
    endtask

    // Reset pulse placed entirely inside the low clock phase.
    task automatic reset_pulse();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_bit = c_RESET_VAL;
        check_bit("async_rst", so, model_bit);
        #2;
        reset = 1'b1;
        #1;
        check_bit("rst_release_hold", so, model_bit);
        @(posedge clk);
        model_edge();
        #1;
        check_bit("post_rst_edge", so, model_bit);
    endtask

    // Flip d and si mid-cycle and restore them before the edge.
    task automatic glitch_cycle();
        logic keep;
        @(negedge clk);
        keep = model_bit;
        #2;
        d  = ~d;
        si = ~si;
        #1;
        check_bit("glitch_mid", so, keep);
        #2;
        d  = ~d;
        si = ~si;
        @(posedge clk);
        model_edge();
        #1;
        check_bit("glitch_edge", so, model_bit);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        model_bit = c_RESET_VAL;
        reset     = 1'b0;
        d         = 1'b1;
        si        = 1'b1;
        se        = 1'b0;

        // Reset held with live inputs and a running clock.
        for (int i = 0; i < 10; i++) begin
            #5;
            se = ~se;
            check_bit("reset_hold", so, c_RESET_VAL);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_bit("release_no_edge", so, c_RESET_VAL);

        // Functional capture.
        run_cycle("func_d1", 1'b1, 1'b0, 1'b0);
        check_bit("func_d1_abs", so, 1'b1);
        run_cycle("func_d0", 1'b0, 1'b0, 1'b0);
        check_bit("func_d0_abs", so, 1'b0);

        // Scan capture, d ignored.
        run_cycle("scan_si0", 1'b1, 1'b0, 1'b1);
        check_bit("scan_si0_abs", so, 1'b0);
        run_cycle("scan_si1", 1'b0, 1'b1, 1'b1);
        check_bit("scan_si1_abs", so, 1'b1);

        // Mode switching.
        run_cycle("mode_a", 1'b1, 1'b1, 1'b0);
        check_bit("mode_a_abs", so, 1'b1);
        run_cycle("mode_b", 1'b0, 1'b1, 1'b1);
        check_bit("mode_b_abs", so, 1'b1);
        run_cycle("mode_c", 1'b0, 1'b0, 1'b0);
        check_bit("mode_c_abs", so, 1'b0);

        // Async reset while holding a 1 in scan mode; next edge loads si=1.
        run_cycle("pre_rst", 1'b0, 1'b1, 1'b1);
        check_bit("pre_rst_abs", so, 1'b1);
        reset_pulse();
        check_bit("post_rst_abs", so, 1'b1);

        // Glitch immunity.
        run_cycle("pre_glitch", 1'b1, 1'b0, 1'b0);
        glitch_cycle();
        run_cycle("pre_glitch2", 1'b0, 1'b1, 1'b1);
        glitch_cycle();

        // Randomized traffic with occasional resets and glitches.
        for (int i = 0; i < 300; i++) begin
            int sel;
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                reset_pulse();
            end else if (sel == 1) begin
                glitch_cycle();
            end else begin
                run_cycle("rand", 1'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
